// File: rtl/mips_pkg.sv
// Shared state, opcode and datapath-select encodings for the multicycle MIPS control path.
// Build option: MIPS_ADDI_EN adds the ADDI_EXEC/ADDI_WB states.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    EXEC      = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
`ifdef MIPS_ADDI_EN
    ,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on mem_ready and are therefore guarded by the timeout counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; pulses timeout on the MEM_TIMEOUT-th waiting cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic waiting,
  output logic timeout
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // The counter only needs to reach MEM_TIMEOUT-1: the last waiting cycle flags timeout itself.
  assign timeout = waiting && (cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (waiting) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Moore control FSM for a multicycle MIPS datapath with a memory-wait timeout.
// Build option: MIPS_ADDI_EN enables decoding of ADDI (opcode 0x08).
module main_ctrl_fsm
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       bus_err
);

  state_t state;
  state_t state_next;
  logic   illegal_op;
  logic   mem_timeout;
  logic   timer_start;
  logic   timer_waiting;

  assign timer_waiting = is_mem_state(state) && !mem_ready;
  // A timeout re-enters FETCH, which must restart the count even from FETCH itself.
  assign timer_start   = mem_timeout || ((state_next != state) && is_mem_state(state_next));

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .waiting (timer_waiting),
    .timeout (mem_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      bus_err <= 1'b0;
    end else begin
      state   <= state_next;
      bus_err <= illegal_op || mem_timeout;
    end
  end

  always_comb begin
    state_next = state;
    illegal_op = 1'b0;
    if (mem_timeout) begin
      state_next = FETCH;
    end else begin
      case (state)
        FETCH:    if (mem_ready) state_next = DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE:     state_next = EXEC;
            OP_LW, OP_SW: state_next = MEM_ADDR;
            OP_BEQ:       state_next = BRANCH;
            OP_J:         state_next = JUMP;
`ifdef MIPS_ADDI_EN
            OP_ADDI:      state_next = ADDI_EXEC;
`endif
            default: begin
              illegal_op = 1'b1;
              state_next = FETCH;
            end
          endcase
        end
        MEM_ADDR: state_next = (opcode == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   if (mem_ready) state_next = MEM_WB;
        MEM_WB:   state_next = FETCH;
        MEM_WR:   if (mem_ready) state_next = FETCH;
        EXEC:     state_next = R_WB;
        R_WB:     state_next = FETCH;
        BRANCH:   state_next = FETCH;
        JUMP:     state_next = FETCH;
`ifdef MIPS_ADDI_EN
        ADDI_EXEC: state_next = ADDI_WB;
        ADDI_WB:   state_next = FETCH;
`endif
        default:  state_next = FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // The instruction and PC+4 are only captured in the cycle memory delivers.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNC;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
`ifdef MIPS_ADDI_EN
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Scoreboard bench for main_ctrl_fsm: stimulus queues the expected output word per cycle,
// a negedge monitor pops and compares it against the packed DUT outputs.
module tb_main_ctrl_fsm;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BAD   = 6'h3F;

  // Field order: pc_write pc_write_cond i_or_d mem_read mem_write ir_write mem_to_reg
  //              reg_dst reg_write alu_src_a alu_src_b[2] alu_op[2] pc_source[2] bus_err
  localparam logic [16:0] E_FETCH_W   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_FETCH_R   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_FETCH_ERR = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_1;
  localparam logic [16:0] E_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] E_MEM_ADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_MEM_RD    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_MEM_WB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] E_MEM_WR    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_EXEC      = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] E_R_WB      = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] E_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] E_JUMP      = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
`ifdef MIPS_ADDI_EN
  localparam logic [16:0] E_ADDI_EXEC = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_ADDI_WB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
`endif

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, bus_err;
  logic [1:0] alu_src_b, alu_op, pc_source;

  typedef struct {
    logic [16:0] vec;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  main_ctrl_fsm #(
    .MEM_TIMEOUT(15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .bus_err       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] got;
  assign got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, bus_err};

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (got !== e.vec) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", e.name, got, e.vec);
      end
    end
  end

  task automatic expect_now(input logic [16:0] v, input string nm);
    exp_t e;
    e.vec  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [5:0] op, input logic rdy, input logic [16:0] v,
                      input string nm);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    expect_now(v, nm);
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = OP_RTYPE;
    mem_ready = 1'b0;
    expect_now(E_FETCH_W, "reset_state");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // lw, zero wait: 5 cycles
    step(OP_LW, 1'b1, E_FETCH_R,  "lw_fetch");
    step(OP_LW, 1'b1, E_DECODE,   "lw_decode");
    step(OP_LW, 1'b1, E_MEM_ADDR, "lw_mem_addr");
    step(OP_LW, 1'b1, E_MEM_RD,   "lw_mem_rd");
    step(OP_LW, 1'b1, E_MEM_WB,   "lw_mem_wb");

    // R-type with three fetch wait cycles; mem_ready in DECODE/EXEC is ignored
    for (int i = 0; i < 3; i++) step(OP_RTYPE, 1'b0, E_FETCH_W, "r_fetch_wait");
    step(OP_RTYPE, 1'b1, E_FETCH_R, "r_fetch_ready");
    step(OP_RTYPE, 1'b1, E_DECODE,  "r_decode");
    step(OP_RTYPE, 1'b1, E_EXEC,    "r_exec");
    step(OP_RTYPE, 1'b0, E_R_WB,    "r_wb");

    step(OP_BEQ, 1'b1, E_FETCH_R, "beq_fetch");
    step(OP_BEQ, 1'b0, E_DECODE,  "beq_decode");
    step(OP_BEQ, 1'b0, E_BRANCH,  "beq_branch");

    step(OP_J, 1'b1, E_FETCH_R, "j_fetch");
    step(OP_J, 1'b0, E_DECODE,  "j_decode");
    step(OP_J, 1'b0, E_JUMP,    "j_jump");

    step(OP_SW, 1'b1, E_FETCH_R,  "sw_fetch");
    step(OP_SW, 1'b0, E_DECODE,   "sw_decode");
    step(OP_SW, 1'b0, E_MEM_ADDR, "sw_mem_addr");
    step(OP_SW, 1'b1, E_MEM_WR,   "sw_mem_wr");

    // lw with two read wait cycles
    step(OP_LW, 1'b1, E_FETCH_R,  "lw2_fetch");
    step(OP_LW, 1'b0, E_DECODE,   "lw2_decode");
    step(OP_LW, 1'b0, E_MEM_ADDR, "lw2_mem_addr");
    step(OP_LW, 1'b0, E_MEM_RD,   "lw2_rd_wait0");
    step(OP_LW, 1'b0, E_MEM_RD,   "lw2_rd_wait1");
    step(OP_LW, 1'b1, E_MEM_RD,   "lw2_rd_ready");
    step(OP_LW, 1'b0, E_MEM_WB,   "lw2_mem_wb");

    // illegal opcode: bus_err one cycle, back in FETCH
    step(OP_BAD, 1'b1, E_FETCH_R,   "bad_fetch");
    step(OP_BAD, 1'b0, E_DECODE,    "bad_decode");
    step(OP_BAD, 1'b0, E_FETCH_ERR, "bad_bus_err");
    step(OP_BAD, 1'b0, E_FETCH_W,   "bad_err_cleared");

    step(OP_ADDI, 1'b1, E_FETCH_R, "addi_fetch");
    step(OP_ADDI, 1'b0, E_DECODE,  "addi_decode");
`ifdef MIPS_ADDI_EN
    step(OP_ADDI, 1'b0, E_ADDI_EXEC, "addi_exec");
    step(OP_ADDI, 1'b0, E_ADDI_WB,   "addi_wb");
`else
    step(OP_ADDI, 1'b0, E_FETCH_ERR, "addi_illegal_err");
    step(OP_ADDI, 1'b0, E_FETCH_W,   "addi_illegal_fetch");
`endif

    // sw with mem_ready held low: 15 MEM_WR cycles, then FETCH with bus_err
    step(OP_SW, 1'b1, E_FETCH_R,  "swto_fetch");
    step(OP_SW, 1'b0, E_DECODE,   "swto_decode");
    step(OP_SW, 1'b0, E_MEM_ADDR, "swto_mem_addr");
    for (int i = 0; i < 15; i++) step(OP_SW, 1'b0, E_MEM_WR, "swto_mem_wr_wait");
    step(OP_SW, 1'b0, E_FETCH_ERR, "swto_bus_err");
    step(OP_SW, 1'b0, E_FETCH_W,   "swto_err_cleared");
    step(OP_SW, 1'b1, E_FETCH_R,   "swto_refetch");

    // jump into a fresh FETCH, then let the fetch itself time out
    step(OP_J, 1'b0, E_DECODE, "fto_decode");
    step(OP_J, 1'b0, E_JUMP,   "fto_jump");
    for (int i = 0; i < 15; i++) step(OP_J, 1'b0, E_FETCH_W, "fto_fetch_wait");
    step(OP_J, 1'b0, E_FETCH_ERR, "fto_bus_err");
    step(OP_J, 1'b0, E_FETCH_W,   "fto_err_cleared");

    // asynchronous reset in the middle of MEM_WB
    step(OP_LW, 1'b1, E_FETCH_R,  "rst_lw_fetch");
    step(OP_LW, 1'b0, E_DECODE,   "rst_lw_decode");
    step(OP_LW, 1'b0, E_MEM_ADDR, "rst_lw_mem_addr");
    step(OP_LW, 1'b1, E_MEM_RD,   "rst_lw_mem_rd");
    @(posedge clk);
    #1 mem_ready = 1'b0;
    #2 reset = 1'b1;
    expect_now(E_FETCH_W, "rst_mid_mem_wb");
    @(posedge clk);
    #1 expect_now(E_FETCH_W, "rst_held");
    @(posedge clk);
    #1;
    reset     = 1'b0;
    opcode    = OP_RTYPE;
    mem_ready = 1'b1;
    expect_now(E_FETCH_R, "post_rst_fetch");
    step(OP_RTYPE, 1'b0, E_DECODE, "post_rst_decode");
    step(OP_RTYPE, 1'b0, E_EXEC,   "post_rst_exec");
    step(OP_RTYPE, 1'b0, E_R_WB,   "post_rst_r_wb");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
